// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the RISC-V instruction fetch stage.
// Included by the fetch unit top and its prefetch FIFO.
package riscv_fetch_pkg;

  localparam int XLEN   = 32;
  localparam int INST_W = 32;

  localparam logic [INST_W-1:0] NOP     = 32'h0000_0013;
  localparam logic [XLEN-1:0]   PC_STEP = 32'd4;

  // Debug-only fetch state; behaviour is carried entirely by the counters.
  localparam logic [0:0] FETCH = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] alignPc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {pc, inst} pairs between instruction memory and the core.
// Flush wins over push and pop; the head reads as zero whenever the FIFO is empty.
module fetch_fifo
  import riscv_fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1),
  parameter int WIDTH = XLEN + INST_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rdPtr_q;
  logic [PTR_W-1:0] wrPtr_q;
  logic [CNT_W-1:0] count_q;
  logic             doPush;
  logic             doPop;

  assign doPop  = pop && (count_q != '0) && !flush;
  assign doPush = push && !flush && ((count_q != CNT_FULL) || doPop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else if (flush) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + PTR_ONE;
      if (doPop)  rdPtr_q <= rdPtr_q + PTR_ONE;
      if (doPush && !doPop) begin
        count_q <= count_q + CNT_ONE;
      end else if (!doPush && doPop) begin
        count_q <= count_q - CNT_ONE;
      end
    end
  end

  // Storage needs no reset: the occupancy count alone decides what is visible.
  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= pushData;
  end

  assign count = count_q;
  assign head  = (count_q != '0) ? mem_q[rdPtr_q] : '0;

endmodule

// File: rtl/riscv_fetch_unit.sv
// Instruction fetch stage: credit-limited requests to an in-order variable-latency
// memory, a prefetch FIFO toward the core, and redirect handling that drops stale responses.
module riscv_fetch_unit
  import riscv_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 4,
  parameter int              CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_data,
  output logic [XLEN-1:0]   inst_pc,
  output logic [0:0]        dbg_state
);

  localparam logic [CNT_W:0]   CREDIT_MAX = (CNT_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [XLEN-1:0]  fetchPc_q, fetchPc_d;
  logic [XLEN-1:0]  respPc_q, respPc_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] dropCnt_q, dropCnt_d;
  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] fifoCount;
  logic [CNT_W:0]   creditUsed;
  logic             reqFire;
  logic             rspDrop;
  logic             fifoPush;
  logic             fifoPop;
  fetch_entry_t     pushEntry;
  fetch_entry_t     headEntry;

  // Buffered plus in-flight fetches never exceed DEPTH, so a response always has a slot.
  assign creditUsed     = {1'b0, fifoCount} + {1'b0, outstanding_q};
  assign imem_req_valid = !reset && !redirect_valid && (creditUsed < CREDIT_MAX);
  assign imem_req_addr  = fetchPc_q;
  assign reqFire        = imem_req_valid && imem_req_ready;

  assign rspDrop  = imem_rsp_valid && (redirect_valid || (dropCnt_q != '0));
  assign fifoPush = imem_rsp_valid && !rspDrop;
  assign fifoPop  = inst_valid && inst_ready;

  assign pushEntry.pc   = respPc_q;
  assign pushEntry.inst = imem_rsp_data;

  always_comb begin
    fetchPc_d     = fetchPc_q;
    respPc_d      = respPc_q;
    dropCnt_d     = dropCnt_q;
    outstanding_d = outstanding_q;
    if (reqFire)        outstanding_d = outstanding_d + CNT_ONE;
    if (imem_rsp_valid) outstanding_d = outstanding_d - CNT_ONE;

    // Everything still in flight after a redirect cycle belongs to the old path.
    if (redirect_valid) begin
      fetchPc_d = alignPc(redirect_pc);
      respPc_d  = alignPc(redirect_pc);
      dropCnt_d = outstanding_d;
    end else begin
      if (reqFire)  fetchPc_d = fetchPc_q + PC_STEP;
      if (fifoPush) respPc_d  = respPc_q + PC_STEP;
      if (rspDrop)  dropCnt_d = dropCnt_q - CNT_ONE;
    end

    state_d = (dropCnt_d != '0) ? DRAIN : FETCH;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetchPc_q     <= RESET_PC;
      respPc_q      <= RESET_PC;
      outstanding_q <= '0;
      dropCnt_q     <= '0;
      state_q       <= FETCH;
    end else begin
      fetchPc_q     <= fetchPc_d;
      respPc_q      <= respPc_d;
      outstanding_q <= outstanding_d;
      dropCnt_q     <= dropCnt_d;
      state_q       <= state_d;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH),
    .CNT_W(CNT_W),
    .WIDTH(XLEN + INST_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (fifoPush),
    .pushData(pushEntry),
    .pop     (fifoPop),
    .flush   (redirect_valid),
    .count   (fifoCount),
    .head    (headEntry)
  );

  assign inst_valid = (fifoCount != '0);
  assign inst_data  = headEntry.inst;
  assign inst_pc    = headEntry.pc;
  assign dbg_state  = state_q;

endmodule
